// File: rtl/bomberman_audio_vol_ramp.sv
// Multi-channel Avalon-MM volume block with click-free ramping.
// Each channel slews its output one LSB per ramp tick toward its target.
module bomberman_audio_vol_ramp #(
  parameter int NUM_CH   = 4,
  parameter int VOL_W    = 3,
  parameter int RAMP_DIV = 1024,
  parameter int ADDR_W   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_CH*VOL_W-1:0] out_port,
  output logic [NUM_CH-1:0]       ramping
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(RAMP_DIV - 1);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_CH + 1);

  logic [PW-1:0] ps_q, ps_d;
  logic          tick;

  logic [NUM_CH-1:0][VOL_W-1:0] tgt_q, tgt_d;
  logic [NUM_CH-1:0][VOL_W-1:0] cur_q, cur_d;
  logic [NUM_CH-1:0][VOL_W-1:0] eff_q, eff_d;

  logic mute_q, mute_d;
  logic ren_q, ren_d;
  logic wr;

  // Upper write-data bits have no meaning in this register map.
  logic unused_wd;
  assign unused_wd = ^writedata[31:VOL_W];

  assign wr = chipselect & ~write_n;

  // Free-running ramp prescaler; tick on its last count.
  always_comb begin
    tick = (ps_q == PS_MAX);
    ps_d = tick ? '0 : ps_q + PW'(1);
  end

  // Register-write decode for targets and control bits.
  always_comb begin
    tgt_d  = tgt_q;
    mute_d = mute_q;
    ren_d  = ren_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr && address == ADDR_W'(k)) begin
        tgt_d[k] = writedata[VOL_W-1:0];
      end
    end
    if (wr && address == A_CTRL) begin
      mute_d = writedata[0];
      ren_d  = writedata[1];
    end
  end

  // Effective targets: pre-edge for ramp steps, post-write for jumps.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      eff_q[k]   = mute_q ? '0 : tgt_q[k];
      eff_d[k]   = mute_d ? '0 : tgt_d[k];
      ramping[k] = (cur_q[k] != eff_q[k]);
    end
  end

  // Per-channel slew: jump when ramping is off, else step on tick.
  always_comb begin
    cur_d = cur_q;
    for (int k = 0; k < NUM_CH; k++) begin
      unique case (1'b1)
        !ren_q: begin
          cur_d[k] = eff_d[k];
        end
        tick && (cur_q[k] < eff_q[k]): begin
          cur_d[k] = cur_q[k] + VOL_W'(1);
        end
        tick && (cur_q[k] > eff_q[k]): begin
          cur_d[k] = cur_q[k] - VOL_W'(1);
        end
        default: begin
          cur_d[k] = cur_q[k];
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ps_q   <= '0;
      tgt_q  <= '0;
      cur_q  <= '0;
      mute_q <= 1'b0;
      ren_q  <= 1'b1;
    end else begin
      ps_q   <= ps_d;
      tgt_q  <= tgt_d;
      cur_q  <= cur_d;
      mute_q <= mute_d;
      ren_q  <= ren_d;
    end
  end

  // Zero-wait read mux straight from the registers.
  always_comb begin
    readdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (address == ADDR_W'(k)) begin
        readdata[16 +: VOL_W] = cur_q[k];
        readdata[0 +: VOL_W]  = tgt_q[k];
      end
    end
    if (address == A_CTRL) begin
      readdata[1:0] = {ren_q, mute_q};
    end
    if (address == A_STAT) begin
      readdata[NUM_CH-1:0] = ramping;
    end
  end

  assign out_port = cur_q;

endmodule

// File: tb/tb_bomberman_audio_vol_ramp.sv
// Directed bench for bomberman_audio_vol_ramp.
// Uses RAMP_DIV=4, NUM_CH=4, VOL_W=3.
module tb_bomberman_audio_vol_ramp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [11:0] out_port;
  logic [3:0]  ramping;

  int nerr = 0;
  int nchk = 0;
  int ecnt = 0;

  bomberman_audio_vol_ramp #(
    .NUM_CH(4), .VOL_W(3), .RAMP_DIV(4), .ADDR_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .ramping(ramping)
  );

  always #5 clk = ~clk;

  // Edges since reset release; ticks land where ecnt % 4 == 0.
  always @(posedge clk) begin
    if (!reset_n) ecnt = 0;
    else ecnt = ecnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    clk1();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a,
                    input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic run_to_tick();
    do clk1(); while (ecnt % 4 != 0);
  endtask

  task automatic align_pre_tick();
    while (ecnt % 4 != 3) clk1();
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) clk1();
    reset_n = 1'b1;

    // 1. reset state
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_ramp", 32'(ramping), 32'h0);
    rd("rst_ctrl", 3'd4, 32'h2);
    rd("rst_stat", 3'd5, 32'h0);
    for (int k = 0; k < 4; k++) rd("rst_ch", 3'(k), 32'h0);

    // 2. ramp ch0 0 -> 5
    wr(3'd0, 32'd5);
    chk("up_ramp0", 32'(ramping), 32'h1);
    chk("up_out0", 32'(out_port), 32'h0);
    for (int v = 1; v <= 5; v++) begin
      run_to_tick();
      chk("up_step", 32'(out_port), 32'(v));
      chk("up_rbit", 32'(ramping), (v < 5) ? 32'h1 : 32'h0);
    end
    rd("up_rd", 3'd0, 32'h0005_0005);

    // 3. reversal mid-ramp
    wr(3'd4, 32'h0);
    wr(3'd0, 32'h0);
    chk("rv_jump0", 32'(out_port), 32'h0);
    wr(3'd4, 32'h2);
    align_pre_tick();
    wr(3'd0, 32'd5);
    chk("rv_oldtgt", 32'(out_port), 32'h0);
    chk("rv_ramp", 32'(ramping), 32'h1);
    for (int v = 1; v <= 3; v++) begin
      run_to_tick();
      chk("rv_up", 32'(out_port), 32'(v));
    end
    wr(3'd0, 32'd1);
    rd("rv_rd", 3'd0, 32'h0003_0001);
    run_to_tick();
    chk("rv_dn2", 32'(out_port), 32'd2);
    run_to_tick();
    chk("rv_dn1", 32'(out_port), 32'd1);
    run_to_tick();
    chk("rv_hold", 32'(out_port), 32'd1);
    chk("rv_done", 32'(ramping), 32'h0);

    // 4. mute down and back
    wr(3'd4, 32'h0);
    for (int k = 0; k < 4; k++) wr(3'(k), 32'd7);
    wr(3'd4, 32'h2);
    chk("mu_full", 32'(out_port), 32'hFFF);
    wr(3'd4, 32'h3);
    for (int v = 6; v >= 0; v--) begin
      run_to_tick();
      chk("mu_dn", 32'(out_port), 32'({4{3'(v)}}));
      chk("mu_rdn", 32'(ramping), (v != 0) ? 32'hF : 32'h0);
      if (v == 3) rd("mu_rd", 3'd1, 32'h0003_0007);
    end
    rd("mu_tgt", 3'd3, 32'h0000_0007);
    wr(3'd4, 32'h2);
    for (int v = 1; v <= 7; v++) begin
      run_to_tick();
      chk("mu_up", 32'(out_port), 32'({4{3'(v)}}));
      chk("mu_rup", 32'(ramping), (v != 7) ? 32'hF : 32'h0);
    end
    rd("mu_end", 3'd2, 32'h0007_0007);

    // 5. ramp disabled: immediate update
    wr(3'd4, 32'h0);
    chk("nr_pre", 32'(out_port), 32'hFFF);
    wr(3'd2, 32'd6);
    chk("nr_jump", 32'(out_port), 32'hFBF);
    chk("nr_ramp", 32'(ramping), 32'h0);
    rd("nr_rd2", 3'd2, 32'h0006_0006);
    wr(3'd3, 32'h8);
    rd("nr_rd3a", 3'd3, 32'h0);
    chk("nr_out3", 32'(out_port), 32'h1BF);
    wr(3'd3, 32'hFF);
    rd("nr_rd3b", 3'd3, 32'h0007_0007);
    chk("nr_outff", 32'(out_port), 32'hFBF);
    rd("nr_ctrl", 3'd4, 32'h0);

    // 6. reset mid-ramp, unmapped writes
    wr(3'd4, 32'h2);
    wr(3'd1, 32'h0);
    chk("rs_ramp", 32'(ramping), 32'h2);
    run_to_tick();
    chk("rs_step", 32'(out_port), 32'hFB7);
    reset_n = 1'b0;
    clk1();
    chk("rs_out", 32'(out_port), 32'h0);
    chk("rs_rbit", 32'(ramping), 32'h0);
    rd("rs_ch1", 3'd1, 32'h0);
    rd("rs_ctrl", 3'd4, 32'h2);
    reset_n = 1'b1;
    wr(3'd7, 32'h5);
    rd("rs_rd7", 3'd7, 32'h0);
    wr(3'd5, 32'hF);
    rd("rs_stat", 3'd5, 32'h0);
    wr(3'd6, 32'h1);
    rd("rs_ctrl2", 3'd4, 32'h2);
    chk("rs_out2", 32'(out_port), 32'h0);
    for (int k = 0; k < 4; k++) rd("rs_chk", 3'(k), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
